axi_sram_responder: RTL

- Single-beat AXI4 slave that terminates the core's load/store master ports.
- Backs a byte-writable word SRAM.
- Read and write channels are independent, with a configurable response latency so bench and simulation can model slow memory.
- Sits on the memory side of the LSU read and write interfaces, or behind an arbiter.

---
 rtl/axi_pkg.sv | 34 +++
 rtl/sram_bw.sv | 36 +++
 rtl/axi_sram_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types and the response-decode helper for the AXI SRAM responder.
// Both the read and the write channel classify transactions with resp_of().
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  // Out-of-window addresses win over a bad burst length; span is 4*DEPTH bytes.
  function automatic resp_t resp_of(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [31:0] base, input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    if (off[32] || (off >= span)) return DECERR;
    if (len != 8'd0) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/sram_bw.sv
// DEPTH x 32 word SRAM with one synchronous read port and one byte-enabled write port.
// A same-cycle read and write to one word returns the old contents.
module sram_bw #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rdEn_i,
  input  logic [AW-1:0] rdAddr_i,
  output logic [31:0]   rdData_o,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [3:0]    wrStrb_i,
  input  logic [31:0]   wrData_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdData_q;

  // Non-blocking updates give read-before-write on a collision.
  always_ff @(posedge clock) begin
    if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
    if (wrEn_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wrStrb_i[b]) begin
          mem_q[wrAddr_i][8*b +: 8] <= wrData_i[8*b +: 8];
        end
      end
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_sram_responder.sv
// Single-beat AXI4 slave in front of a byte-writable word SRAM, with independent
// read and write FSMs and a programmable response latency on each channel.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic [ID_W-1:0] rid,
  output logic            rlast,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     awaddr,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [ID_W-1:0] bid
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [3:0]  RLAT = 4'(READ_LAT);
  localparam logic [3:0]  WLAT = 4'(WRITE_LAT);

  rd_state_t         rState_q, rState_d;
  logic [3:0]        rCnt_q, rCnt_d;
  logic [31:0]       arAddr_q;
  logic [ID_W-1:0]   rId_q;
  resp_t             rResp_q;
  logic              arFire, sramRdEn;
  logic [31:0]       sramRdData, rdOff;

  wr_state_t         wState_q, wState_d;
  logic [3:0]        wCnt_q, wCnt_d;
  logic              haveAw_q, haveAw_d, haveW_q, haveW_d;
  logic [31:0]       awAddr_q, wData_q, wrOff;
  logic [3:0]        wStrb_q;
  logic [ID_W-1:0]   bId_q;
  resp_t             wResp_q;
  logic              awFire, wFire, commit;
  logic              unusedBits;

  assign arFire = (rState_q == R_IDLE) && arvalid;
  assign rdOff  = arAddr_q - BASE;

  always_ff @(posedge clock) begin
    if (reset) begin
      rState_q <= R_IDLE;
      rCnt_q   <= '0;
      arAddr_q <= '0;
      rId_q    <= '0;
      rResp_q  <= OKAY;
    end else begin
      rState_q <= rState_d;
      rCnt_q   <= rCnt_d;
      if (arFire) begin
        arAddr_q <= araddr;
        rId_q    <= arid;
        rResp_q  <= resp_of(araddr, arlen, BASE, SPAN);
      end
    end
  end

  // The SRAM is sampled on the last wait cycle so its output register lines up with R_RESP.
  always_comb begin
    rState_d = rState_q;
    rCnt_d   = rCnt_q;
    sramRdEn = 1'b0;
    case (rState_q)
      R_IDLE: begin
        if (arvalid) begin
          rState_d = R_WAIT;
          rCnt_d   = RLAT;
        end
      end
      R_WAIT: begin
        if (rCnt_q == 4'd0) begin
          sramRdEn = 1'b1;
          rState_d = R_RESP;
        end else begin
          rCnt_d = rCnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) rState_d = R_IDLE;
      end
      default: rState_d = R_IDLE;
    endcase
  end

  assign arready = (rState_q == R_IDLE);
  assign rvalid  = (rState_q == R_RESP);
  assign rdata   = (rvalid && (rResp_q == OKAY)) ? sramRdData : 32'd0;
  assign rresp   = rResp_q;
  assign rid     = rId_q;
  assign rlast   = 1'b1;

  assign awFire = (wState_q == W_IDLE) && !haveAw_q && awvalid;
  assign wFire  = (wState_q == W_IDLE) && !haveW_q && wvalid;
  assign wrOff  = awAddr_q - BASE;

  always_ff @(posedge clock) begin
    if (reset) begin
      wState_q <= W_IDLE;
      wCnt_q   <= '0;
      haveAw_q <= 1'b0;
      haveW_q  <= 1'b0;
      awAddr_q <= '0;
      bId_q    <= '0;
      wResp_q  <= OKAY;
      wData_q  <= '0;
      wStrb_q  <= '0;
    end else begin
      wState_q <= wState_d;
      wCnt_q   <= wCnt_d;
      haveAw_q <= haveAw_d;
      haveW_q  <= haveW_d;
      if (awFire) begin
        awAddr_q <= awaddr;
        bId_q    <= awid;
        wResp_q  <= resp_of(awaddr, awlen, BASE, SPAN);
      end
      if (wFire) begin
        wData_q <= wdata;
        wStrb_q <= wstrb;
      end
    end
  end

  // AW and W are collected in any order; the wait starts once both halves are present.
  always_comb begin
    wState_d = wState_q;
    wCnt_d   = wCnt_q;
    haveAw_d = haveAw_q;
    haveW_d  = haveW_q;
    commit   = 1'b0;
    case (wState_q)
      W_IDLE: begin
        haveAw_d = haveAw_q | awFire;
        haveW_d  = haveW_q | wFire;
        if (haveAw_d && haveW_d) begin
          wState_d = W_WAIT;
          wCnt_d   = WLAT;
        end
      end
      W_WAIT: begin
        if (wCnt_q == 4'd0) begin
          commit   = (wResp_q == OKAY);
          wState_d = W_RESP;
        end else begin
          wCnt_d = wCnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          haveAw_d = 1'b0;
          haveW_d  = 1'b0;
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  assign awready = (wState_q == W_IDLE) && !haveAw_q;
  assign wready  = (wState_q == W_IDLE) && !haveW_q;
  assign bvalid  = (wState_q == W_RESP);
  assign bresp   = wResp_q;
  assign bid     = bId_q;

  sram_bw #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clock    (clock),
    .rdEn_i   (sramRdEn),
    .rdAddr_i (rdOff[AW+1:2]),
    .rdData_o (sramRdData),
    .wrEn_i   (commit && !reset),
    .wrAddr_i (wrOff[AW+1:2]),
    .wrStrb_i (wStrb_q),
    .wrData_i (wData_q)
  );

  assign unusedBits = ^{arsize, arburst, awsize, awburst, wlast,
                        rdOff[31:AW+2], rdOff[1:0], wrOff[31:AW+2], wrOff[1:0]};

endmodule
